// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: default word
// format, fixed-point constants, saturation bounds and the neuron FSM states.
package nn_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 16;

    // 1.0 and 0.5 in the default Q16.16 format
    localparam logic [WIDTH_DEF-1:0] ONE  = 32'd1 << FRAC_DEF;
    localparam logic [WIDTH_DEF-1:0] HALF = 32'd1 << (FRAC_DEF - 1);

    // Signed saturation bounds of the default word
    localparam logic [WIDTH_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [WIDTH_DEF-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } nn_state_e;

endpackage

// File: rtl/act_hsig.sv
// Combinational hard sigmoid: y = clamp((s >>> 2) + 0.5, 0, 1.0).
// Used by neuron_fwd only when NEURON_FWD_ACT_EN is defined.
module act_hsig #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [WIDTH-1:0] s,
    output logic        [WIDTH-1:0] y
);

    // One guard bit so the +0.5 offset can never wrap
    localparam logic signed [WIDTH:0] HALF_X = {{WIDTH{1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [WIDTH:0] ONE_X  = {{WIDTH{1'b0}}, 1'b1} << FRAC;

    logic signed [WIDTH:0] t_s;

    // Quarter slope plus offset, then clamp into [0, 1.0]
    always_comb begin
        t_s = ($signed({s[WIDTH-1], s}) >>> 2) + HALF_X;
        y   = {WIDTH{1'b0}};
        if (t_s < $signed({(WIDTH+1){1'b0}})) begin
            y = {WIDTH{1'b0}};
        end else if (t_s > ONE_X) begin
            y = ONE_X[WIDTH-1:0];
        end else begin
            y = t_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_2in.sv
// Two-input signed multiplier producing the full double-width product.
module mult_2in #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/neuron_fwd.sv
// Forward-pass neuron y = act(sum(x_i*w_i) + b) with one time-shared
// multiplier. Build option NEURON_FWD_ACT_EN selects a hard-sigmoid output;
// otherwise the saturated sum is passed through linearly.
module neuron_fwd
    import nn_pkg::*;
#(
    parameter int NUM   = 2,
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM*WIDTH-1:0] i_x,
    input  logic [NUM*WIDTH-1:0] i_w,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [WIDTH-1:0]     o_y,
    output logic                 o_valid,
    input  logic                 o_ready
);

    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int ACC_W = 2 * WIDTH + $clog2(NUM) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);

    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    nn_state_e state_r;
    nn_state_e next_state_s;

    logic [NUM*WIDTH-1:0]     x_r;
    logic [NUM*WIDTH-1:0]     w_r;
    logic signed [WIDTH-1:0]  b_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [IDX_W-1:0]         idx_r;
    logic [WIDTH-1:0]         o_y_r;
    logic                     o_valid_r;

    logic signed [WIDTH-1:0]   x_sel_s;
    logic signed [WIDTH-1:0]   w_sel_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;
    logic signed [ACC_W-1:0]   b_ext_s;
    logic signed [ACC_W-1:0]   fin_sum_s;
    logic signed [ACC_W-1:0]   shr_s;
    logic signed [WIDTH-1:0]   sat_s;
    logic [WIDTH-1:0]          act_s;

    assign x_sel_s = x_r[idx_r*WIDTH +: WIDTH];
    assign w_sel_s = w_r[idx_r*WIDTH +: WIDTH];

    mult_2in #(.WIDTH(WIDTH)) u_mult (
        .a (x_sel_s),
        .b (w_sel_s),
        .p (prod_s)
    );

    assign prod_ext_s = {{(ACC_W-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
    assign b_ext_s    = {{(ACC_W-WIDTH){b_r[WIDTH-1]}}, b_r};
    assign fin_sum_s  = acc_r + (b_ext_s <<< FRAC);
    assign shr_s      = fin_sum_s >>> FRAC;

    // Clamp the rescaled sum into the signed output word
    always_comb begin
        sat_s = {WIDTH{1'b0}};
        if (shr_s > SAT_HI) begin
            sat_s = SAT_HI[WIDTH-1:0];
        end else if (shr_s < SAT_LO) begin
            sat_s = SAT_LO[WIDTH-1:0];
        end else begin
            sat_s = shr_s[WIDTH-1:0];
        end
    end

`ifdef NEURON_FWD_ACT_EN
    act_hsig #(.WIDTH(WIDTH), .FRAC(FRAC)) u_act (
        .s (sat_s),
        .y (act_s)
    );
`else
    assign act_s = sat_s;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: accept, NUM MAC cycles, one finish cycle, hold
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid) next_state_s = MAC;
                else         next_state_s = IDLE;
            end
            MAC: begin
                if (idx_r == IDX_LAST) next_state_s = FIN;
                else                   next_state_s = MAC;
            end
            FIN: begin
                next_state_s = DONE;
            end
            DONE: begin
                if (o_ready) next_state_s = IDLE;
                else         next_state_s = DONE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and registered result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r       <= {(NUM*WIDTH){1'b0}};
            w_r       <= {(NUM*WIDTH){1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            o_y_r     <= {WIDTH{1'b0}};
            o_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        x_r   <= i_x;
                        w_r   <= i_w;
                        b_r   <= i_b;
                        acc_r <= {ACC_W{1'b0}};
                        idx_r <= {IDX_W{1'b0}};
                    end
                end
                MAC: begin
                    acc_r <= acc_r + prod_ext_s;
                    if (idx_r == IDX_LAST) idx_r <= {IDX_W{1'b0}};
                    else                   idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
                FIN: begin
                    o_y_r     <= act_s;
                    o_valid_r <= 1'b1;
                end
                DONE: begin
                    if (o_ready) o_valid_r <= 1'b0;
                end
                default: begin
                    o_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready = (state_r == IDLE);
    assign o_y     = o_y_r;
    assign o_valid = o_valid_r;

endmodule

// File: tb/tb_neuron_fwd.sv
// Self-checking bench for neuron_fwd: a NUM=2 and a NUM=4 instance driven
// with directed and random vectors against a plain-arithmetic reference.
module tb_neuron_fwd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst2, rst4;
    logic [63:0]  x2, w2;
    logic [31:0]  b2, y2;
    logic         iv2, ir2, ov2, or2;
    logic [127:0] x4, w4;
    logic [31:0]  b4, y4;
    logic         iv4, ir4, ov4, or4;

    neuron_fwd #(.NUM(2), .WIDTH(32), .FRAC(16)) dut2 (
        .clk(clk), .rst(rst2), .i_x(x2), .i_w(w2), .i_b(b2), .i_valid(iv2),
        .i_ready(ir2), .o_y(y2), .o_valid(ov2), .o_ready(or2)
    );

    neuron_fwd #(.NUM(4), .WIDTH(32), .FRAC(16)) dut4 (
        .clk(clk), .rst(rst4), .i_x(x4), .i_w(w4), .i_b(b4), .i_valid(iv4),
        .i_ready(ir4), .o_y(y4), .o_valid(ov4), .o_ready(or4)
    );

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: exact integer dot product, floor rescale, clamp, activation
    function automatic logic [31:0] ref_y(input logic [127:0] xs, input logic [127:0] ws,
                                          input logic [31:0] b, input int n);
        logic signed [127:0] sum, xa, wa, s, y;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            xa  = $signed(xs[i*32 +: 32]);
            wa  = $signed(ws[i*32 +: 32]);
            sum = sum + xa * wa;
        end
        xa  = $signed(b);
        sum = sum + xa * 65536;
        s   = sum >>> 16;
        if (s > 128'sd2147483647)       s = 128'sd2147483647;
        else if (s < -128'sd2147483648) s = -128'sd2147483648;
`ifdef NEURON_FWD_ACT_EN
        y = (s >>> 2) + 128'sd32768;
        if (y < 128'sd0)          y = 128'sd0;
        else if (y > 128'sd65536) y = 128'sd65536;
`else
        y = s;
`endif
        return y[31:0];
    endfunction

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return $urandom();
        return 32'($urandom_range(0, 32'h003F_FFFF)) - 32'h0020_0000;
    endfunction

    function automatic logic [127:0] rnd_vec();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = rnd_word();
        return v;
    endfunction

    task automatic drive(input int sel, input logic [127:0] xs, input logic [127:0] ws,
                         input logic [31:0] b, input logic v);
        if (sel == 2) begin
            x2 = xs[63:0]; w2 = ws[63:0]; b2 = b; iv2 = v;
        end else begin
            x4 = xs; w4 = ws; b4 = b; iv4 = v;
        end
    endtask

    task automatic set_or(input int sel, input logic v);
        if (sel == 2) or2 = v;
        else          or4 = v;
    endtask

    function automatic logic get_ov(input int sel);
        return (sel == 2) ? ov2 : ov4;
    endfunction

    function automatic logic get_ir(input int sel);
        return (sel == 2) ? ir2 : ir4;
    endfunction

    function automatic logic [31:0] get_y(input int sel);
        return (sel == 2) ? y2 : y4;
    endfunction

    // Wait (bounded) for o_valid; returns edges counted after the accept edge
    task automatic wait_valid(input int sel, output int edges);
        edges = 0;
        while (!get_ov(sel) && edges < 40) begin
            @(posedge clk); @(negedge clk);
            edges++;
        end
    endtask

    // One full transaction starting at a negedge with the DUT idle
    task automatic run_vec(input int sel, input logic [127:0] xs, input logic [127:0] ws,
                           input logic [31:0] b, input int hold, input logic [31:0] exp);
        int edges;
        check("idle_ready", 64'(get_ir(sel)), 64'd1);
        drive(sel, xs, ws, b, 1'b1);
        set_or(sel, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(sel, rnd_vec(), rnd_vec(), rnd_word(), 1'b0);
        check("busy_ready", 64'(get_ir(sel)), 64'd0);
        wait_valid(sel, edges);
        check("latency", 64'(edges), 64'(sel + 1));
        check("result", 64'(get_y(sel)), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            drive(sel, rnd_vec(), rnd_vec(), rnd_word(), 1'b1);
            @(posedge clk); @(negedge clk);
            check("hold_valid", 64'(get_ov(sel)), 64'd1);
            check("hold_y", 64'(get_y(sel)), 64'(exp));
            check("hold_ready", 64'(get_ir(sel)), 64'd0);
        end
        drive(sel, rnd_vec(), rnd_vec(), rnd_word(), 1'b0);
        set_or(sel, 1'b1);
        @(posedge clk); @(negedge clk);
        check("drop_valid", 64'(get_ov(sel)), 64'd0);
        check("back_ready", 64'(get_ir(sel)), 64'd1);
        set_or(sel, 1'b0);
    endtask

    initial begin : main
        logic [127:0] xa, wa, xb, wb;
        logic [31:0]  ba, bb, ea, eb, e_lin, e_act;
        int edges;

        rst2 = 1'b0; rst4 = 1'b0;
        drive(2, 128'd0, 128'd0, 32'd0, 1'b0);
        drive(4, 128'd0, 128'd0, 32'd0, 1'b0);
        or2 = 1'b0; or4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready2", 64'(ir2), 64'd1);
        check("rst_valid2", 64'(ov2), 64'd0);
        check("rst_y2", 64'(y2), 64'd0);
        check("rst_ready4", 64'(ir4), 64'd1);
        check("rst_valid4", 64'(ov4), 64'd0);
        rst2 = 1'b1; rst4 = 1'b1;
        @(negedge clk);

        // Directed: 1.0*0.5 + 2.0*0.25 = 1.0, with backpressure on the output
`ifdef NEURON_FWD_ACT_EN
        e_act = 32'h0000_C000; e_lin = e_act;
`else
        e_lin = 32'h0001_0000; e_act = e_lin;
`endif
        run_vec(2, {64'd0, 32'h0002_0000, 32'h0001_0000},
                   {64'd0, 32'h0000_4000, 32'h0000_8000}, 32'd0, 5, e_lin);

        // Directed: positive saturation (100000.0)
`ifdef NEURON_FWD_ACT_EN
        e_lin = 32'h0001_0000;
`else
        e_lin = 32'h7FFF_FFFF;
`endif
        run_vec(2, {64'd0, 32'h0064_0000, 32'h0064_0000},
                   {64'd0, 32'h01F4_0000, 32'h01F4_0000}, 32'd0, 0, e_lin);

        // Directed: negative sum -4.0
`ifdef NEURON_FWD_ACT_EN
        e_lin = 32'h0000_0000;
`else
        e_lin = 32'hFFFC_0000;
`endif
        run_vec(2, {64'd0, 32'h0001_0000, 32'h0001_0000},
                   {64'd0, 32'hFFFE_0000, 32'hFFFE_0000}, 32'd0, 0, e_lin);

        // Random vectors on both widths
        for (int t = 0; t < 16; t++) begin
            xa = rnd_vec(); wa = rnd_vec(); ba = rnd_word();
            run_vec(2, xa, wa, ba, int'($urandom_range(0, 2)), ref_y(xa, wa, ba, 2));
        end
        for (int t = 0; t < 8; t++) begin
            xa = rnd_vec(); wa = rnd_vec(); ba = rnd_word();
            run_vec(4, xa, wa, ba, int'($urandom_range(0, 2)), ref_y(xa, wa, ba, 4));
        end

        // Leave a known non-zero result on the NUM=4 output before the abort
        xa = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        wa = {32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000};
        run_vec(4, xa, wa, 32'h0003_0000, 0, ref_y(xa, wa, 32'h0003_0000, 4));

        // Reset during the second MAC cycle
        xa = rnd_vec(); wa = rnd_vec(); ba = rnd_word();
        drive(4, xa, wa, ba, 1'b1);
        @(posedge clk); @(negedge clk);
        drive(4, xa, wa, ba, 1'b0);
        @(posedge clk); @(negedge clk);
        rst4 = 1'b0;
        #1;
        check("abort_valid", 64'(ov4), 64'd0);
        check("abort_y", 64'(y4), 64'd0);
        check("abort_ready", 64'(ir4), 64'd1);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        xb = rnd_vec(); wb = rnd_vec(); bb = rnd_word();
        run_vec(4, xb, wb, bb, 0, ref_y(xb, wb, bb, 4));

        // Back-to-back with i_valid and o_ready held high
        xa = rnd_vec(); wa = rnd_vec(); ba = rnd_word(); ea = ref_y(xa, wa, ba, 2);
        xb = rnd_vec(); wb = rnd_vec(); bb = rnd_word(); eb = ref_y(xb, wb, bb, 2);
        drive(2, xa, wa, ba, 1'b1);
        or2 = 1'b1;
        @(posedge clk); @(negedge clk);
        drive(2, xb, wb, bb, 1'b1);
        wait_valid(2, edges);
        check("b2b_lat_a", 64'(edges), 64'd3);
        check("b2b_res_a", 64'(y2), 64'(ea));
        @(posedge clk); @(negedge clk);
        check("b2b_idle", 64'(ir2), 64'd1);
        @(posedge clk); @(negedge clk);
        check("b2b_accept", 64'(ir2), 64'd0);
        wait_valid(2, edges);
        check("b2b_lat_b", 64'(edges), 64'd3);
        check("b2b_res_b", 64'(y2), 64'(eb));
        drive(2, xb, wb, bb, 1'b0);
        @(posedge clk); @(negedge clk);
        check("b2b_drop", 64'(ov2), 64'd0);
        or2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
